// File: rtl/mem_access_seq.sv
// Load/store sequencer for a fixed-latency data memory.
// Sub-doubleword stores do a read-modify-write of the addressed doubleword.
module mem_access_seq #(
   parameter int unsigned MEM_LAT = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        is_store,
   input  logic [3:0]  qualTipo,
   input  logic        sign_ext,
   input  logic [63:0] addr,
   input  logic [63:0] store_data,
   input  logic [63:0] mem_rdata,
   output logic [63:0] mem_addr,
   output logic        mem_wr,
   output logic [63:0] mem_wdata,
   output logic [63:0] load_data,
   output logic        busy,
   output logic        done
);

   localparam logic [3:0] LAT = 4'(MEM_LAT);

   typedef enum logic [1:0] {
      IDLE,
      READ_WAIT,
      WRITE,
      DONE
   } state_t;

   state_t      state;
   state_t      state_nx;
   logic [3:0]  cnt;
   logic [3:0]  cnt_nx;
   logic [63:0] addr_q;
   logic [63:0] b_q;
   logic        st_q;
   logic        sx_q;
   logic [3:0]  q_q;
   logic [63:0] wdata_q;
   logic [63:0] load_q;
   logic [63:0] merged;
   logic [63:0] extracted;
   logic        accept;
   logic        leave;

   assign accept = (state == IDLE) && start;
   assign leave  = (state == READ_WAIT) && (cnt == 4'd1);

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      unique case (state)
         IDLE: begin
            if (start) begin
               state_nx = READ_WAIT;
               cnt_nx   = LAT;
            end
         end
         READ_WAIT: begin
            cnt_nx = cnt - 4'd1;
            if (cnt == 4'd1) begin
               state_nx = st_q ? WRITE : DONE;
            end
         end
         WRITE:   state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      merged = b_q;
      unique case (q_q)
         4'd0:    merged = {mem_rdata[63:32], b_q[31:0]};
         4'd1:    merged = {mem_rdata[63:16], b_q[15:0]};
         4'd2:    merged = {mem_rdata[63:8], b_q[7:0]};
         default: merged = b_q;
      endcase
   end

   always_comb begin
      extracted = mem_rdata;
      unique case (q_q)
         4'd0: extracted = {{32{sx_q & mem_rdata[31]}},
                            mem_rdata[31:0]};
         4'd1: extracted = {{48{sx_q & mem_rdata[15]}},
                            mem_rdata[15:0]};
         4'd2: extracted = {{56{sx_q & mem_rdata[7]}},
                            mem_rdata[7:0]};
         default: extracted = mem_rdata;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         cnt     <= 4'd0;
         addr_q  <= 64'd0;
         b_q     <= 64'd0;
         st_q    <= 1'b0;
         sx_q    <= 1'b0;
         q_q     <= 4'd0;
         wdata_q <= 64'd0;
         load_q  <= 64'd0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         if (accept) begin
            addr_q <= addr;
            b_q    <= store_data;
            st_q   <= is_store;
            sx_q   <= sign_ext;
            q_q    <= qualTipo;
         end
         // read data is only valid on the edge that ends the wait
         if (leave && st_q) begin
            wdata_q <= merged;
         end
         if (leave && !st_q) begin
            load_q <= extracted;
         end
      end
   end

   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign load_data = load_q;
   assign mem_wr    = (state == WRITE);
   assign busy      = (state != IDLE);
   assign done      = (state == DONE);

endmodule

// File: tb/tb_mem_access_seq.sv
// Bench for mem_access_seq: per-cycle model compare plus directed
// literal checks for data merge/extract, latency, pokes and reset.
module tb_mem_access_seq;

   localparam int L = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        start1 = 1'b0;
   logic        start15 = 1'b0;
   logic        is_store = 1'b0;
   logic [3:0]  qualTipo = 4'd0;
   logic        sign_ext = 1'b0;
   logic [63:0] addr = 64'd0;
   logic [63:0] store_data = 64'd0;
   logic [63:0] mem_rdata = 64'd0;

   logic [63:0] mem_addr, mem_wdata, load_data;
   logic        mem_wr, busy, done;
   logic [63:0] a1, w1, l1, a15, w15, l15;
   logic        wr1, busy1, done1, wr15, busy15, done15;

   int checks = 0;
   int errors = 0;
   int wr_cnt = 0;
   int done_cnt = 0;

   mem_access_seq #(.MEM_LAT(L)) u_dut (
      .clk(clk), .reset(reset), .start(start),
      .is_store(is_store), .qualTipo(qualTipo),
      .sign_ext(sign_ext), .addr(addr),
      .store_data(store_data), .mem_rdata(mem_rdata),
      .mem_addr(mem_addr), .mem_wr(mem_wr),
      .mem_wdata(mem_wdata), .load_data(load_data),
      .busy(busy), .done(done)
   );

   mem_access_seq #(.MEM_LAT(1)) u_d1 (
      .clk(clk), .reset(reset), .start(start1),
      .is_store(is_store), .qualTipo(qualTipo),
      .sign_ext(sign_ext), .addr(addr),
      .store_data(store_data), .mem_rdata(mem_rdata),
      .mem_addr(a1), .mem_wr(wr1),
      .mem_wdata(w1), .load_data(l1),
      .busy(busy1), .done(done1)
   );

   mem_access_seq #(.MEM_LAT(15)) u_d15 (
      .clk(clk), .reset(reset), .start(start15),
      .is_store(is_store), .qualTipo(qualTipo),
      .sign_ext(sign_ext), .addr(addr),
      .store_data(store_data), .mem_rdata(mem_rdata),
      .mem_addr(a15), .mem_wr(wr15),
      .mem_wdata(w15), .load_data(l15),
      .busy(busy15), .done(done15)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic int nbytes(input logic [3:0] q);
      case (q)
         4'd0:    return 4;
         4'd1:    return 2;
         4'd2:    return 1;
         default: return 8;
      endcase
   endfunction

   function automatic logic [63:0] mask(input int n);
      if (n == 8) return '1;
      return (64'd1 << (8 * n)) - 64'd1;
   endfunction

   function automatic logic [63:0] f_merge(input logic [3:0] q,
      input logic [63:0] b, input logic [63:0] rd);
      logic [63:0] mk;
      mk = mask(nbytes(q));
      return (rd & ~mk) | (b & mk);
   endfunction

   function automatic logic [63:0] f_ext(input logic [3:0] q,
      input logic sx, input logic [63:0] rd);
      int n;
      logic [63:0] mk, v;
      n = nbytes(q);
      mk = mask(n);
      v = rd & mk;
      if (sx && n < 8 && v[8 * n - 1]) v = v | ~mk;
      return v;
   endfunction

   // model: age counts edges since acceptance
   logic        m_active = 1'b0;
   int          m_age = 0;
   logic        m_st = 1'b0;
   logic        m_sx = 1'b0;
   logic [3:0]  m_q = 4'd0;
   logic [63:0] m_addr = 64'd0;
   logic [63:0] m_b = 64'd0;
   logic [63:0] m_wdata = 64'd0;
   logic [63:0] m_load = 64'd0;

   function automatic int tot(input logic st);
      return st ? L + 2 : L + 1;
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_active <= 1'b0;
         m_age    <= 0;
         m_st     <= 1'b0;
         m_sx     <= 1'b0;
         m_q      <= 4'd0;
         m_addr   <= 64'd0;
         m_b      <= 64'd0;
         m_wdata  <= 64'd0;
         m_load   <= 64'd0;
      end else if (!m_active) begin
         if (start) begin
            m_active <= 1'b1;
            m_age    <= 0;
            m_st     <= is_store;
            m_sx     <= sign_ext;
            m_q      <= qualTipo;
            m_addr   <= addr;
            m_b      <= store_data;
         end
      end else if (m_age == tot(m_st) - 1) begin
         m_active <= 1'b0;
      end else begin
         m_age <= m_age + 1;
         if (m_age + 1 == L) begin
            if (m_st) m_wdata <= f_merge(m_q, m_b, mem_rdata);
            else      m_load  <= f_ext(m_q, m_sx, mem_rdata);
         end
      end
   end

   always @(negedge clk) begin
      if (reset) begin
         chk("cyc_busy", 64'(busy), 64'(m_active));
         chk("cyc_done", 64'(done),
             64'(m_active && m_age == tot(m_st) - 1));
         chk("cyc_wr", 64'(mem_wr),
             64'(m_active && m_st && m_age == L));
         chk("cyc_addr", mem_addr, m_addr);
         chk("cyc_wdata", mem_wdata, m_wdata);
         chk("cyc_load", load_data, m_load);
      end
   end

   always @(posedge clk) begin
      if (mem_wr) wr_cnt <= wr_cnt + 1;
      if (done) done_cnt <= done_cnt + 1;
   end

   task automatic do_op(input string tag, input logic st,
      input logic [3:0] q, input logic sx, input logic [63:0] a,
      input logic [63:0] b, input logic [63:0] rd,
      input logic [63:0] exp_val, input int exp_lat,
      input logic poke);
      int w0, d0, m;
      @(posedge clk);
      #1;
      is_store = st; qualTipo = q; sign_ext = sx;
      addr = a; store_data = b; mem_rdata = rd;
      start = 1'b1;
      w0 = wr_cnt;
      d0 = done_cnt;
      @(posedge clk);
      #1;
      start = 1'b0;
      addr = ~a; store_data = ~b; is_store = ~st;
      qualTipo = q ^ 4'h3; sign_ext = ~sx;
      m = 0;
      while (m < 40) begin
         @(negedge clk);
         if (done) break;
         if (poke) start = (m == 1);
         @(posedge clk);
         m++;
      end
      chk({tag, "_lat"}, 64'(m + 1), 64'(exp_lat));
      chk({tag, "_val"}, st ? mem_wdata : load_data, exp_val);
      if (poke) begin
         start = 1'b1;
         @(posedge clk);
         #1;
         start = 1'b0;
      end
      repeat (6) @(posedge clk);
      #1;
      chk({tag, "_wrs"}, 64'(wr_cnt - w0), st ? 64'd1 : 64'd0);
      chk({tag, "_dones"}, 64'(done_cnt - d0), 64'd1);
   endtask

   task automatic set_start(input int which, input logic v);
      if (which == 1) start1 = v;
      else start15 = v;
   endtask

   function automatic logic sel_done(input int which);
      return (which == 1) ? done1 : done15;
   endfunction

   function automatic logic sel_busy(input int which);
      return (which == 1) ? busy1 : busy15;
   endfunction

   task automatic lat_op(input string tag, input int which,
                         input logic st, input int exp_lat);
      int m;
      @(posedge clk);
      #1;
      is_store = st; qualTipo = 4'd0; sign_ext = 1'b0;
      set_start(which, 1'b1);
      @(posedge clk);
      #1;
      set_start(which, 1'b0);
      m = 0;
      while (m < 40) begin
         @(negedge clk);
         if (sel_done(which)) break;
         @(posedge clk);
         m++;
      end
      chk(tag, 64'(m + 1), 64'(exp_lat));
      @(posedge clk);
      #1;
      chk({tag, "_idle"}, 64'(sel_busy(which)), 64'd0);
   endtask

   initial begin
      int m, d0;
      #12;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_wr", 64'(mem_wr), 64'd0);
      chk("rst_addr", mem_addr, 64'd0);
      chk("rst_wdata", mem_wdata, 64'd0);
      chk("rst_load", load_data, 64'd0);

      // start raised together with reset release
      @(posedge clk);
      #1;
      reset = 1'b1;
      is_store = 1'b0; qualTipo = 4'd2; sign_ext = 1'b1;
      addr = 64'h40; mem_rdata = 64'h0000_0000_0000_00F1;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      m = 0;
      while (m < 40 && !done) begin
         @(posedge clk);
         #1;
         m++;
      end
      chk("first_lat", 64'(m + 1), 64'(L + 1));
      chk("first_val", load_data, 64'hFFFF_FFFF_FFFF_FFF1);

      do_op("st_word", 1, 4'd0, 0, 64'h100,
            64'hAAAA_BBBB_CCCC_DDDD, 64'h1111_2222_3333_4444,
            64'h1111_2222_CCCC_DDDD, 4, 0);
      do_op("st_byte", 1, 4'd2, 0, 64'h108,
            64'h0000_0000_0000_005A, 64'hFFFF_FFFF_FFFF_FF00,
            64'hFFFF_FFFF_FFFF_FF5A, 4, 0);
      do_op("st_half", 1, 4'd1, 1, 64'h110,
            64'h0000_0000_0000_1234, 64'hFFFF_FFFF_FFFF_FF00,
            64'hFFFF_FFFF_FFFF_1234, 4, 0);
      do_op("st_dw_q15", 1, 4'hF, 0, 64'h118,
            64'h0123_4567_89AB_CDEF, 64'hFFFF_0000_FFFF_0000,
            64'h0123_4567_89AB_CDEF, 4, 0);
      do_op("ld_byte_s", 0, 4'd2, 1, 64'h120,
            64'h0, 64'h0123_4567_89AB_CD80,
            64'hFFFF_FFFF_FFFF_FF80, 3, 0);
      do_op("ld_byte_z", 0, 4'd2, 0, 64'h128,
            64'h0, 64'h0123_4567_89AB_CD80,
            64'h0000_0000_0000_0080, 3, 0);
      do_op("ld_word_s", 0, 4'd0, 1, 64'h130,
            64'h0, 64'h1234_5678_8000_0001,
            64'hFFFF_FFFF_8000_0001, 3, 0);
      do_op("ld_half_z", 0, 4'd1, 0, 64'h138,
            64'h0, 64'hDEAD_BEEF_CAFE_F00D,
            64'h0000_0000_0000_F00D, 3, 0);
      do_op("ld_half_s", 0, 4'd1, 1, 64'h140,
            64'h0, 64'hDEAD_BEEF_CAFE_F00D,
            64'hFFFF_FFFF_FFFF_F00D, 3, 0);
      do_op("ld_dw_sx", 0, 4'd3, 1, 64'h148,
            64'h0, 64'h8000_0000_0000_0001,
            64'h8000_0000_0000_0001, 3, 0);
      do_op("ld_poke", 0, 4'd0, 0, 64'h150,
            64'h0, 64'h0000_0000_7FFF_FFFF,
            64'h0000_0000_7FFF_FFFF, 3, 1);
      do_op("st_poke", 1, 4'd0, 0, 64'h158,
            64'h5555_6666_7777_8888, 64'h9999_AAAA_BBBB_CCCC,
            64'h9999_AAAA_7777_8888, 4, 1);

      // abort a store while it is writing
      @(posedge clk);
      #1;
      is_store = 1'b1; qualTipo = 4'd0; addr = 64'h200;
      store_data = 64'h1; mem_rdata = 64'h2;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      m = 0;
      while (m < 20) begin
         @(negedge clk);
         if (mem_wr) break;
         m++;
      end
      chk("abort_saw_wr", 64'(mem_wr), 64'd1);
      #1;
      reset = 1'b0;
      #1;
      chk("abort_wr", 64'(mem_wr), 64'd0);
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_done", 64'(done), 64'd0);
      chk("abort_addr", mem_addr, 64'd0);
      chk("abort_wdata", mem_wdata, 64'd0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      d0 = done_cnt;
      repeat (5) @(posedge clk);
      #1;
      chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
      do_op("post_rst", 0, 4'd2, 0, 64'h208,
            64'h0, 64'h0000_0000_0000_00C3,
            64'h0000_0000_0000_00C3, 3, 0);

      lat_op("lat1_ld", 1, 0, 2);
      lat_op("lat1_st", 1, 1, 3);
      lat_op("lat15_ld", 15, 0, 16);
      lat_op("lat15_st", 15, 1, 17);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
